// File: rtl/mem_wb_pkg.sv
// Shared codes, widths and FSM state type for the memory/write-back stage.
// Also holds the load-address legality helper shared by the stage decode.
package mem_wb_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] OPSEL_SHIFT_REG   = 3'b000;
    localparam logic [2:0] OPSEL_ARITH_LOGIC = 3'b001;
    localparam logic [2:0] OPSEL_MEM_WRITE   = 3'b100;
    localparam logic [2:0] OPSEL_MEM_READ    = 3'b101;

    localparam logic [2:0] LD_BYTE  = 3'b000;
    localparam logic [2:0] LD_HALF  = 3'b001;
    localparam logic [2:0] LD_WORD  = 3'b011;
    localparam logic [2:0] LD_BYTEU = 3'b100;
    localparam logic [2:0] LD_HALFU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_RD,
        S_MEM_WR
    } state_e;

    // True when a load sub-op is undefined or its address is misaligned.
    function automatic logic load_bad(input logic [2:0] op, input logic [1:0] a);
        case (op)
            LD_BYTE, LD_BYTEU: load_bad = 1'b0;
            LD_HALF, LD_HALFU: load_bad = a[0];
            LD_WORD:           load_bad = |a;
            default:           load_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// Memory request/response bus between the stage (master) and data memory (slave).
interface mem_wb_if import mem_wb_pkg::*; #(parameter int DATA_W = DATA_W_DEF) ();

    logic [DATA_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/load_extend.sv
// Little-endian lane select of a read word followed by sign or zero extension.
module load_extend import mem_wb_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        op,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_lanes [4];
    logic [15:0] half_lanes [2];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign byte_lanes[gi] = rdata[8*gi +: 8];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        assign half_lanes[gi] = rdata[16*gi +: 16];
    end

    assign byte_sel = byte_lanes[offset];
    assign half_sel = half_lanes[offset[1]];

    always_comb begin
        case (op)
            LD_BYTE:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BYTEU: data = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_HALF:  data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_HALFU: data = {{(DATA_W-16){1'b0}}, half_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: ALU results write back in one cycle, loads and stores
// run a level-held memory request with an acknowledge timeout.
module mem_wb_stage import mem_wb_pkg::*; #(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] aluout,
    input  logic              carry,
    input  logic [2:0]        opselect_in,
    input  logic [2:0]        operation_in,
    input  logic [4:0]        dest_in,
    input  logic [DATA_W-1:0] store_data_in,
    mem_wb_if.master          mem,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              carry_flag,
    output logic              err
);

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        op_reg;
    logic [1:0]        off_reg;
    logic [4:0]        dest_reg;
    logic [DATA_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_rd_reg;
    logic              mem_wr_reg;

    logic              is_alu;
    logic              is_rd;
    logic              is_wr;
    logic              bad;
    logic [DATA_W-1:0] ext_data;

    assign ready_out     = (state_reg == S_IDLE);
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign mem.mem_rd    = mem_rd_reg;
    assign mem.mem_wr    = mem_wr_reg;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata  (mem.mem_rdata),
        .op     (op_reg),
        .offset (off_reg),
        .data   (ext_data)
    );

    // Decode of the result offered in IDLE; bad covers illegal class, sub-op and alignment.
    always_comb begin
        is_alu = (opselect_in == OPSEL_SHIFT_REG) || (opselect_in == OPSEL_ARITH_LOGIC);
        is_rd  = (opselect_in == OPSEL_MEM_READ);
        is_wr  = (opselect_in == OPSEL_MEM_WRITE);
        bad    = 1'b0;
        if (is_rd) begin
            bad = load_bad(operation_in, aluout[1:0]);
        end else if (is_wr) begin
            bad = |aluout[1:0];
        end else if (!is_alu) begin
            bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            op_reg        <= '0;
            off_reg       <= '0;
            dest_reg      <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            wb_en         <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
            carry_flag    <= 1'b0;
            err           <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            err   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (valid_in) begin
                        if (bad) begin
                            err <= 1'b1;
                        end else if (is_alu) begin
                            wb_en   <= (dest_in != 5'd0);
                            wb_addr <= dest_in;
                            wb_data <= aluout;
                            if (opselect_in == OPSEL_ARITH_LOGIC) begin
                                carry_flag <= carry;
                            end
                        end else begin
                            mem_addr_reg <= {aluout[DATA_W-1:2], 2'b00};
                            cnt_reg      <= '0;
                            op_reg       <= operation_in;
                            off_reg      <= aluout[1:0];
                            dest_reg     <= dest_in;
                            if (is_rd) begin
                                mem_rd_reg <= 1'b1;
                                state_reg  <= S_MEM_RD;
                            end else begin
                                mem_wr_reg    <= 1'b1;
                                mem_wdata_reg <= store_data_in;
                                state_reg     <= S_MEM_WR;
                            end
                        end
                    end
                end
                S_MEM_RD, S_MEM_WR: begin
                    // An acknowledge always beats the timeout, even on the last allowed cycle.
                    if (mem.mem_ack) begin
                        mem_rd_reg <= 1'b0;
                        mem_wr_reg <= 1'b0;
                        state_reg  <= S_IDLE;
                        if (state_reg == S_MEM_RD) begin
                            wb_en   <= (dest_reg != 5'd0);
                            wb_addr <= dest_reg;
                            wb_data <= ext_data;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        mem_rd_reg <= 1'b0;
                        mem_wr_reg <= 1'b0;
                        err        <= 1'b1;
                        state_reg  <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width.
REQ-002 Parameter: ACK_TIMEOUT, 15, max cycles waiting for mem_ack.
REQ-003 CLOCK  in  1  single clock, rising edge.
REQ-004 RESET  in  1  reset, asynchronous, active-low.
REQ-005 valid_in  in  1  execute-stage result valid.
REQ-006 ready_out  out  1  stage accepts a result this cycle.
REQ-007 aluout  in  32  ALU result or effective address.
REQ-008 carry  in  1  ALU carry.
REQ-009 opselect_in  in  3  class: SHIFT_REG 000, ARITH_LOGIC 001, MEM_WRITE 100, MEM_READ 101.
REQ-010 operation_in  in  3  load sub-op: LOADBYTE 000, LOADHALF 001, LOADWORD 011, LOADBYTEU 100, LOADHALFU 101.
REQ-011 dest_in  in  5  destination register index.
REQ-012 store_data_in  in  32  store word.
REQ-013 mem_addr  out  32  word-aligned memory address.
REQ-014 mem_rd / mem_wr  out  1 each  memory read/write request, level, held until ack.
REQ-015 mem_wdata  out  32  store data.
REQ-016 mem_rdata  in  32  read data, valid with mem_ack.
REQ-017 mem_ack  in  1  memory completion strobe.
REQ-018 wb_en  out  1  register-file write strobe, one cycle.
REQ-019 wb_addr  out  5  write register index.
REQ-020 wb_data  out  32  write data.
REQ-021 carry_flag  out  1  registered carry status.
REQ-022 err  out  1  one-cycle error pulse.

Function
REQ-023 FSM states SHALL be IDLE, MEM_RD, MEM_WR; ready_out = 1 only in IDLE.
REQ-024 Accept = valid_in && ready_out; valid_in outside IDLE ignored (upstream holds).
REQ-025 SHIFT_REG/ARITH_LOGIC accepted: next cycle wb_en=1, wb_data=aluout, wb_addr=dest_in; stay IDLE (latency 1, back-to-back allowed).
REQ-026 carry_flag SHALL update to carry only on accepted ARITH_LOGIC; otherwise holds.
REQ-027 MEM_READ accepted: enter MEM_RD next cycle; mem_rd=1, mem_addr={aluout[31:2],2'b00} held until mem_ack.
REQ-028 On mem_ack in MEM_RD: cycle after, wb_en=1 with extracted data; return IDLE.
REQ-029 Extraction little-endian: byte = mem_rdata[8*a[1:0]+:8], half = mem_rdata[16*a[1]+:16]; LOADBYTE/LOADHALF sign-extend, U variants zero-extend, LOADWORD passes word.
REQ-030 MEM_WRITE accepted: enter MEM_WR; mem_wr=1, mem_wdata=store_data_in, mem_addr as REQ-027; on mem_ack return IDLE, no wb_en.
REQ-031 Timeout counter counts cycles in MEM_RD/MEM_WR; reaching ACK_TIMEOUT without ack drops request, pulses err, returns IDLE, no wb_en.
REQ-032 mem_ack in the cycle counter reaches ACK_TIMEOUT SHALL win (normal completion, no err).
REQ-033 Misaligned (half with a[0]=1; word load/store with a[1:0]!=0) or undefined load sub-op or opselect: no memory request, err pulse next cycle, no wb_en, stay IDLE.
REQ-034 dest_in=0 SHALL suppress wb_en (r0 hardwired zero).
REQ-035 mem_ack in IDLE SHALL be ignored.

Reset
REQ-036 RESET low SHALL immediately force IDLE, counter 0, mem_rd=mem_wr=wb_en=err=carry_flag=0, mem_addr=mem_wdata=wb_data=0, wb_addr=0, ready_out=1 after release.
REQ-037 Reset mid-transaction SHALL abandon it with no wb_en or err afterwards.

Structure
REQ-038 Package mem_wb_pkg SHALL hold opselect/load sub-op codes, DATA_W default, and the state enum.
REQ-039 One sub-module load_extend (combinational lane select plus sign/zero extension) SHALL be instantiated.

Verification
REQ-040 ARITH_LOGIC aluout=0x00000005, carry=1, dest=3 -> next cycle wb_en=1, wb_addr=3, wb_data=5, carry_flag=1.
REQ-041 LOADBYTE addr 0x103, ack after 2 cycles with rdata 0x80FF1234 -> mem_addr=0x100, wb_data=0xFFFFFF80; LOADBYTEU -> 0x00000080.
REQ-042 LOADHALF addr 0x102, rdata 0x8001FFFF -> wb_data=0xFFFF8001; LOADHALF addr 0x101 -> err pulse, mem_rd never asserted.
REQ-043 MEM_WRITE addr 0x20, data 0xDEADBEEF, no ack -> mem_wr held 15 cycles, then dropped, err pulse, ready_out=1.
REQ-044 RESET low during MEM_RD wait -> mem_rd=0 same cycle; later mem_ack produces no wb_en.
